// File: rtl/antares_div_pkg.sv
// Shared constants for the divide controller: FSM state encoding,
// divider iteration count and the divide-by-zero quotient.
package antares_div_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int DIV_ITER = 32;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/antares_div_ctrl.sv
// Divide sequencer and HI/LO owner. Accepts a request in IDLE, issues a
// one-cycle start pulse to the external divider, waits for div_stall to
// drop and commits quotient->LO, remainder->HI. MTHI/MTLO writes apply in
// any state and win over a coincident writeback for their own register.
// A flushed divide is drained (result discarded) before returning to IDLE.
// Optional macro ANTARES_DIV_ZERO_BYPASS_EN: a zero divisor is resolved at
// the accept edge without starting the divider.
module antares_div_ctrl
  import antares_div_pkg::*;
#(
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_signed,
  input  logic [31:0] req_dividend,
  input  logic [31:0] req_divisor,
  output logic        req_ready,
  input  logic        flush,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        div_op_divs,
  output logic        div_op_divu,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_stall
);

  logic [1:0]  state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic        signed_q, signed_d;

  logic accept;
  logic zero_div;
  logic wb;

  assign accept = (state_q == S_IDLE) && req_valid && !flush;
  // Result is taken only from WAIT; a flush in the same cycle discards it.
  assign wb     = (state_q == S_WAIT) && !flush && !div_stall;

`ifdef ANTARES_DIV_ZERO_BYPASS_EN
  assign zero_div = (req_divisor == 32'h0);
`else
  assign zero_div = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && !zero_div) state_d = S_ISSUE;
      S_ISSUE: state_d = flush ? S_DRAIN : S_WAIT;
      S_WAIT:  begin
        if (flush)           state_d = S_DRAIN;
        else if (!div_stall) state_d = S_IDLE;
      end
      S_DRAIN: if (!div_stall) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latch and HI/LO update; MT writes override the divider result
  always_comb begin
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    signed_d   = signed_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    if (accept) begin
      dividend_d = req_dividend;
      divisor_d  = req_divisor;
      signed_d   = req_signed;
    end
    if (wb) begin
      hi_d = div_remainder;
      lo_d = div_quotient;
    end
    if (accept && zero_div) begin
      hi_d = req_dividend;
      lo_d = (req_signed && req_dividend[31]) ? 32'h1 : DIV_ZERO_Q;
    end
    if (mthi_we) hi_d = wdata;
    if (mtlo_we) lo_d = wdata;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q       <= HILO_RST;
      lo_q       <= HILO_RST;
      dividend_q <= 32'h0;
      divisor_q  <= 32'h0;
      signed_q   <= 1'b0;
    end else begin
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      signed_q   <= signed_d;
    end
  end

  // Outputs decoded from state; start pulses exist only in ISSUE
  always_comb begin
    req_ready   = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    div_op_divs = (state_q == S_ISSUE) &&  signed_q;
    div_op_divu = (state_q == S_ISSUE) && !signed_q;
  end

  assign hi           = hi_q;
  assign lo           = lo_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

endmodule

// File: tb/tb_antares_div_ctrl.sv
// Directed bench for antares_div_ctrl with a behavioural 32-iteration
// divider and a queue of expected HI/LO results.
module tb_antares_div_ctrl;
  import antares_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_signed;
  logic [31:0] req_dividend, req_divisor;
  logic        req_ready;
  logic        flush, mthi_we, mtlo_we;
  logic [31:0] wdata, hi, lo;
  logic        busy, div_op_divs, div_op_divu;
  logic [31:0] div_dividend, div_divisor;
  logic [31:0] div_quotient, div_remainder;
  logic        div_stall;

  int checks = 0;
  int errors = 0;
  int divs_cnt = 0, divu_cnt = 0, both_cnt = 0;
  int n;

  typedef struct { logic [31:0] hi; logic [31:0] lo; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  antares_div_ctrl #(.HILO_RST(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_signed(req_signed),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_ready(req_ready), .flush(flush),
    .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy),
    .div_op_divs(div_op_divs), .div_op_divu(div_op_divu),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_stall(div_stall)
  );

  // Behavioural divider: stall rises on the edge sampling the start pulse
  // and stays high for DIV_ITER cycles.
  int dcnt;
  always @(posedge clk) begin
    if (div_op_divs) divs_cnt++;
    if (div_op_divu) divu_cnt++;
    if (div_op_divs && div_op_divu) both_cnt++;
    if (rst) begin
      div_stall <= 1'b0; dcnt <= 0;
      div_quotient <= 32'h0; div_remainder <= 32'h0;
    end else if (div_op_divs || div_op_divu) begin
      div_stall <= 1'b1; dcnt <= DIV_ITER - 1;
      if (div_divisor == 32'h0) begin
        div_quotient <= 32'hFFFF_FFFF; div_remainder <= div_dividend;
      end else if (div_op_divs) begin
        div_quotient  <= $signed(div_dividend) / $signed(div_divisor);
        div_remainder <= $signed(div_dividend) % $signed(div_divisor);
      end else begin
        div_quotient  <= div_dividend / div_divisor;
        div_remainder <= div_dividend % div_divisor;
      end
    end else if (div_stall) begin
      if (dcnt == 0) div_stall <= 1'b0;
      else           dcnt <= dcnt - 1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle and check the ISSUE cycle.
  task automatic start_req(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int pu, ps;
    pu = divu_cnt; ps = divs_cnt;
    req_valid = 1'b1; req_signed = sgn; req_dividend = a; req_divisor = b;
    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("issue_busy", {31'b0, busy}, 32'd1);
    chk("issue_ready", {31'b0, req_ready}, 32'd0);
    chk("issue_divs", {31'b0, div_op_divs}, {31'b0, sgn});
    chk("issue_divu", {31'b0, div_op_divu}, {31'b0, !sgn});
    chk("issue_dividend", div_dividend, a);
    chk("issue_divisor", div_divisor, b);
    tick();
    chk("pulse_once", {31'b0, div_op_divs | div_op_divu}, 32'd0);
    chk("pulse_count", (divu_cnt - pu) + (divs_cnt - ps), 32'd1);
  endtask

  // Wait for busy to drop; count includes the two cycles already spent.
  task automatic wait_idle(output int cyc);
    cyc = 1;
    while (busy && cyc < 100) begin
      tick(); cyc++;
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s_sb_empty observed=0 expected=1", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_hi"}, hi, e.hi);
      chk({tag, "_lo"}, lo, e.lo);
    end
  endtask

  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
    int c;
    sb.push_back('{hi: er, lo: eq});
    start_req(sgn, a, b);
    wait_idle(c);
    chk({tag, "_latency"}, c, DIV_ITER + 2);
    pop_check(tag);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_signed = 1'b0;
    req_dividend = 32'h0; req_divisor = 32'h0;
    flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; wdata = 32'h0;
    tick(); tick();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_ops", {30'b0, div_op_divs, div_op_divu}, 32'd0);
    chk("rst_dividend", div_dividend, 32'h0);
    rst = 1'b0;
    tick();

    // Unsigned divide
    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

    // Flush mid-WAIT: drain, discard, HI/LO untouched
    start_req(1'b0, 32'd1000, 32'd10);
    repeat (5) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    chk("drain_busy", {31'b0, busy}, 32'd1);
    chk("drain_ready", {31'b0, req_ready}, 32'd0);
    wait_idle(n);
    chk("drain_bounded", {31'b0, (n < 100)}, 32'd1);
    chk("drain_hi", hi, 32'd2);
    chk("drain_lo", lo, 32'd14);

    // Signed divide, accepted straight after the drain
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);

    // MTLO during WAIT is overwritten; MTHI in writeback cycle wins for HI
    sb.push_back('{hi: 32'hA5A5_A5A5, lo: 32'hFFFF_FFF2});
    start_req(1'b1, 32'hFFFF_FF9C, 32'd7);
    n = 1;
    while (n < 10) begin tick(); n++; end
    mtlo_we = 1'b1; wdata = 32'h1234_5678; tick(); n++; mtlo_we = 1'b0;
    chk("mtlo_wait", lo, 32'h1234_5678);
    chk("mtlo_busy", {31'b0, busy}, 32'd1);
    while (n < DIV_ITER + 1) begin tick(); n++; end
    mthi_we = 1'b1; wdata = 32'hA5A5_A5A5; tick(); mthi_we = 1'b0;
    chk("mthi_wb_busy", {31'b0, busy}, 32'd0);
    pop_check("mthi_wb");

    // Reset while in WAIT, then a clean divide
    start_req(1'b0, 32'd50, 32'd5);
    repeat (8) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_ready", {31'b0, req_ready}, 32'd1);
    do_div("after_rst", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1);

    // Flush coincident with request in IDLE: dropped
    n = divu_cnt + divs_cnt;
    req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'd8; req_divisor = 32'd2;
    flush = 1'b1; tick(); req_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_busy", {31'b0, busy}, 32'd0);
    tick();
    chk("idle_flush_nopulse", divu_cnt + divs_cnt, n);
    chk("idle_flush_lo", lo, 32'd2);

    // Divide by zero
`ifdef ANTARES_DIV_ZERO_BYPASS_EN
    n = divu_cnt + divs_cnt;
    req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'd55; req_divisor = 32'd0;
    tick(); req_valid = 1'b0;
    chk("dz_busy", {31'b0, busy}, 32'd0);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'd55);
    req_valid = 1'b1; req_signed = 1'b1; req_dividend = 32'h8000_0005;
    tick(); req_valid = 1'b0;
    chk("dzs_busy", {31'b0, busy}, 32'd0);
    chk("dzs_lo", lo, 32'h1);
    chk("dzs_hi", hi, 32'h8000_0005);
    tick();
    chk("dz_nopulse", divu_cnt + divs_cnt, n);
`else
    do_div("divu_55_0", 1'b0, 32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55);
`endif

    chk("never_both_ops", both_cnt, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/antares_div_ctrl.md
Name: antares_div_ctrl

Overview:
Sequencer and HI/LO owner for the multi-cycle 32-bit divider. It accepts divide requests from the execute stage and registers the operands. It issues the single-cycle start pulse the divider requires, tracks completion, and commits quotient/remainder into the architectural LO/HI registers. It also services MTHI/MTLO writes and pipeline flushes, and exposes busy so the hazard unit can stall MFHI/MFLO and back-to-back divides.

Parameters:
HILO_RST, 32'h0, reset value of HI and LO.

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  1  divide request from EX
req_signed  in  1  1 = DIV, 0 = DIVU
req_dividend  in  32  dividend operand
req_divisor  in  32  divisor operand
req_ready  out  1  request accepted this cycle (high only in IDLE)
flush  in  1  pipeline flush; abandons in-flight divide
mthi_we  in  1  write HI from wdata
mtlo_we  in  1  write LO from wdata
wdata  in  32  MTHI/MTLO data
hi  out  32  architectural HI (remainder)
lo  out  32  architectural LO (quotient)
busy  out  1  divide pending; HI/LO not yet final
div_op_divs  out  1  divider signed start pulse
div_op_divu  out  1  divider unsigned start pulse
div_dividend  out  32  registered dividend to divider
div_divisor  out  32  registered divisor to divider
div_quotient  in  32  divider quotient
div_remainder  in  32  divider remainder
div_stall  in  1  divider active flag

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On reset: state=IDLE, hi=lo=HILO_RST, busy=0, div_op_*=0, div_dividend=div_divisor=0, req_ready=1.
- States:
  - IDLE: req_ready=1. req_valid&!flush -> latch operands and signed flag, go to ISSUE.
  - ISSUE: exactly one cycle. Assert div_op_divs or div_op_divu per latched flag, never both. div_stall is not sampled here. Go to WAIT; if flush, go to DRAIN.
  - WAIT: when div_stall=0, write lo<=div_quotient and hi<=div_remainder at that edge, then go to IDLE. flush -> DRAIN.
  - DRAIN: wait for div_stall=0, discard the result, go to IDLE. req_ready=0.
- busy=1 in ISSUE, WAIT and DRAIN. It drops on the same edge as the writeback.
- Latency: accept edge E0. Pulse during cycle E0..E1. Divider iterates 32 cycles. WAIT sees div_stall=0 in the 34th cycle after E0, so HI/LO are valid from the 35th cycle.
- div_op_* is never asserted outside ISSUE; the divider must never see a held start.
- MTHI/MTLO apply in any state at the next edge. If coincident with writeback, the MT write wins for its register and the other register takes the divider result.
- flush in IDLE with req_valid: request dropped. flush during DRAIN: no effect.
- Reset mid-operation: the controller returns to IDLE. The divider is reset by the same rst and produces no writeback.
- Divide-by-zero with the macro absent: issued normally; HI/LO take whatever the divider produces.

Optional Feature:
ANTARES_DIV_ZERO_BYPASS_EN
- Defined: in IDLE, req_divisor==0 skips ISSUE/WAIT. At the accept edge, lo<=32'hFFFFFFFF and hi<=req_dividend; busy never rises and the divider is not started. For DIV, lo<=(dividend[31] ? 32'h1 : 32'hFFFFFFFF).
- Undefined: no zero check; behaviour as above.

Decomposition:
- Shared package antares_div_pkg holds:
  - state encoding localparams S_IDLE, S_ISSUE, S_WAIT, S_DRAIN (2-bit);
  - DIV_ITER=32;
  - constant DIV_ZERO_Q=32'hFFFFFFFF.
- No sub-module. The HI/LO register pair and FSM stay in one file; the divider is instantiated by the parent, not inside this block.

Test Plan:
- DIVU 100/7 -> single div_op_divu pulse in ISSUE. busy high 34 cycles, then lo=14, hi=2. req_ready low while busy.
- DIV -7/2 (32'hFFFFFFF9, 2) -> div_op_divs pulse. lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIVU 1000/10, flush 5 cycles after accept -> DRAIN until div_stall=0. hi/lo keep prior values (e.g. 2/14), busy then 0, next request accepted.
- DIV in flight, mthi_we wdata=32'hA5A5A5A5 in the writeback cycle -> hi=32'hA5A5A5A5, lo=quotient. mtlo during WAIT is later overwritten by the quotient.
- Assert rst in WAIT -> hi=lo=HILO_RST and busy=0 next cycle. A new request issues cleanly, with no stale writeback.
- With ANTARES_DIV_ZERO_BYPASS_EN: DIVU 55/0 -> next cycle lo=32'hFFFFFFFF, hi=55, busy never 1, no div_op pulse. Without the macro: normal 34-cycle issue.
